// File: rtl/dmem_stream_loader_pkg.sv
// dmem_stream_loader_pkg: shared widths and loader state encoding
package dmem_stream_loader_pkg;
    localparam int DATA_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = DATA_W / BYTE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);
    localparam int DMEM_DEPTH     = 65536;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_RECV  = 2'd1,
        LDR_WRITE = 2'd2,
        LDR_DONE  = 2'd3
    } ldr_state_t;
endpackage

// File: rtl/dmem_stream_loader_byte_word_packer.sv
// byte_word_packer: shifts stream bytes into a big-endian word, pulses on the last byte
module byte_word_packer
    import dmem_stream_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_fire,
    input  logic [BYTE_W-1:0] in_data,
    output logic [DATA_W-1:0] word,
    output logic              word_valid
);
    logic [IDX_W-1:0] idx;

    assign word_valid = in_fire && idx == IDX_W'(BYTES_PER_WORD - 1);

    // first byte ends up in the top lane after all shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (in_fire) begin
            idx  <= word_valid ? '0 : idx + 1'b1;
            word <= {word[DATA_W-BYTE_W-1:0], in_data};
        end
    end
endmodule

// File: rtl/dmem_stream_loader.sv
// dmem_stream_loader: streams bytes into dmem words; DMEM_LDR_CSUM_EN adds a word checksum output
module dmem_stream_loader
    import dmem_stream_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wd,
    input  logic              cpu_we,
    output logic [ADDR_W-1:0] dmem_a,
    output logic [DATA_W-1:0] dmem_wd,
    output logic              dmem_we,
    output logic              busy,
    output logic              done,
`ifdef DMEM_LDR_CSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    output logic              cpu_hold
);
    ldr_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rem;
    logic [DATA_W-1:0] word;
    logic              word_valid;
    logic              pass;
    logic              in_fire;

    assign pass     = state == LDR_IDLE || state == LDR_DONE;
    assign in_fire  = in_valid && in_ready;
    assign cpu_hold = busy;

    byte_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pass && start),
        .in_fire   (in_fire),
        .in_data   (in_data),
        .word      (word),
        .word_valid(word_valid)
    );

    // CPU owns the port outside a load; the loader drives it only while writing
    always_comb begin
        dmem_a  = pass ? cpu_a : addr;
        dmem_wd = pass ? cpu_wd : word;
        dmem_we = pass ? cpu_we : state == LDR_WRITE;
    end

    // load sequencer with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LDR_IDLE;
            addr     <= '0;
            rem      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef DMEM_LDR_CSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                LDR_IDLE, LDR_DONE: if (start) begin
`ifdef DMEM_LDR_CSUM_EN
                    csum <= '0;
`endif
                    if (word_cnt != '0) begin
                        state    <= LDR_RECV;
                        addr     <= base_addr;
                        rem      <= word_cnt;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end else begin
                        state <= LDR_DONE;
                        done  <= 1'b1;
                    end
                end
                LDR_RECV: if (word_valid) begin
                    state    <= LDR_WRITE;
                    in_ready <= 1'b0;
                end
                LDR_WRITE: begin
                    addr <= addr + 1'b1;
                    rem  <= rem - 1'b1;
`ifdef DMEM_LDR_CSUM_EN
                    csum <= csum + word;
`endif
                    if (rem == ADDR_W'(1)) begin
                        state <= LDR_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= LDR_RECV;
                        in_ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_stream_loader.sv
// tb_dmem_stream_loader: randomized stream loads checked against a word-list model
module tb_dmem_stream_loader;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [15:0] base_addr = 0;
    logic [15:0] word_cnt = 0;
    logic        in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready;
    logic [15:0] cpu_a = 0;
    logic [31:0] cpu_wd = 0;
    logic        cpu_we = 0;
    logic [15:0] dmem_a;
    logic [31:0] dmem_wd;
    logic        dmem_we;
    logic        busy;
    logic        done;
    logic        cpu_hold;
`ifdef DMEM_LDR_CSUM_EN
    logic [31:0] csum;
`endif

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    typedef struct {
        int          c;
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        obs[$];
    logic [7:0] src[$];

    dmem_stream_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .word_cnt (word_cnt),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .cpu_a    (cpu_a),
        .cpu_wd   (cpu_wd),
        .cpu_we   (cpu_we),
        .dmem_a   (dmem_a),
        .dmem_wd  (dmem_wd),
        .dmem_we  (dmem_we),
        .busy     (busy),
        .done     (done),
`ifdef DMEM_LDR_CSUM_EN
        .csum     (csum),
`endif
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (dmem_we) obs.push_back('{cyc, dmem_a, dmem_wd});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int n);
        src.delete();
        repeat (n) src.push_back(8'($urandom));
    endtask

    task automatic load(input logic [15:0] base, input logic [15:0] cnt, input int vmode,
                        input bit noise, input bit snoise, output logic [31:0] sum);
        wr_t exp[$];
        int  k, t, c0, dc;
        sum = 0;
        for (int i = 0; i < int'(cnt); i++) begin
            logic [31:0] w;
            w = {src[4*i], src[4*i+1], src[4*i+2], src[4*i+3]};
            exp.push_back('{0, base + 16'(i), w});
            sum += w;
        end
        start = 1;
        base_addr = base;
        word_cnt = cnt;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 0;
        obs.delete();
        if (cnt == 0) begin
            @(negedge clk);
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
            repeat (3) @(negedge clk);
            chk("zero_writes", obs.size(), 0);
`ifdef DMEM_LDR_CSUM_EN
            chk("zero_csum", csum, 0);
`endif
            return;
        end
        k = 0;
        t = 0;
        while (k < 4 * int'(cnt) && t < 4000) begin
            in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? !t[0] : 1'($urandom_range(0, 1));
            in_data = src[k];
            cpu_we = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cpu_a = 16'($urandom);
            cpu_wd = $urandom;
            start = snoise && $urandom_range(0, 7) == 0;
            base_addr = 16'($urandom);
            word_cnt = 16'($urandom);
            @(negedge clk);
            if (t == 0) begin
                chk("recv_busy", busy, 1);
                chk("recv_hold", cpu_hold, 1);
                chk("recv_ready", in_ready, 1);
                chk("recv_done", done, 0);
            end
            if (in_valid && in_ready) begin
                if (k % 4 == 3) exp[k/4].c = cyc + 1;
                k++;
            end
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 0;
        cpu_we = 0;
        start = 0;
        if (k < 4 * int'(cnt)) chk("stream_timeout", k, 4 * int'(cnt));
        dc = -1;
        for (int i = 0; i < 20 && dc < 0; i++) begin
            @(negedge clk);
            if (done) dc = cyc;
        end
        chk("done_cycle", dc, exp[$].c + 1);
        chk("done_busy", busy, 0);
        chk("done_hold", cpu_hold, 0);
        chk("nwrites", obs.size(), exp.size());
        for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
            chk("wr_addr", obs[i].a, exp[i].a);
            chk("wr_data", obs[i].d, exp[i].d);
            chk("wr_cycle", obs[i].c, exp[i].c);
        end
        if (vmode == 0 && obs.size() > 0) begin
            chk("first_lat", obs[0].c, c0 + 4);
            for (int i = 1; i < obs.size(); i++) chk("word_gap", obs[i].c - obs[i-1].c, 5);
        end
`ifdef DMEM_LDR_CSUM_EN
        chk("csum", csum, sum);
`endif
    endtask

    initial begin
        logic [31:0] s;
        #2;
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hold", cpu_hold, 0);
`ifdef DMEM_LDR_CSUM_EN
        chk("rst_csum", csum, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1;
        cpu_a = 5;
        cpu_wd = 32'hDEADBEEF;
        cpu_we = 1;
        #1;
        chk("pt_a", dmem_a, 5);
        chk("pt_wd", dmem_wd, 32'hDEADBEEF);
        chk("pt_we", dmem_we, 1);
        chk("pt_busy", busy, 0);
        chk("pt_done", done, 0);
        cpu_we = 0;

        src = '{8'h06, 8'h09, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01, 8'h02};
        load(16'd0, 16'd2, 0, 0, 0, s);
        chk("basic_w0", obs[0].d, 32'h06090001);
        chk("basic_w1", obs[1].d, 32'h00020102);
`ifdef DMEM_LDR_CSUM_EN
        chk("basic_csum", csum, 32'h060B0103);
`endif

        src = '{8'h01, 8'h03, 8'h02, 8'h03};
        load(16'd3, 16'd1, 1, 0, 0, s);
        chk("thr_w", obs[0].d, 32'h01030203);
        chk("thr_a", obs[0].a, 3);

        fill(8);
        load(16'hFFFF, 16'd2, 0, 0, 0, s);
        chk("wrap_a1", obs[1].a, 0);

        fill(12);
        load(16'($urandom), 16'd3, 2, 1, 1, s);

        fill(4);
        start = 1;
        base_addr = 7;
        word_cnt = 1;
        @(posedge clk);
        #1;
        start = 0;
        obs.delete();
        in_valid = 1;
        in_data = src[0];
        @(posedge clk);
        #1;
        in_data = src[1];
        @(posedge clk);
        #1;
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_we", dmem_we, 0);
        repeat (2) @(posedge clk);
        chk("mid_rst_writes", obs.size(), 0);
        #1;
        rst_n = 1;
        load(16'h0042, 16'd0, 0, 0, 0, s);
        fill(4);
        load(16'd9, 16'd1, 0, 0, 0, s);

        repeat (6) begin
            int n;
            n = $urandom_range(1, 4);
            fill(4 * n);
            load(16'($urandom), 16'(n), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/dmem_stream_loader.md
Name: dmem_stream_loader

Overview:
- Upstream write-side stage for the data memory `dmem`.
- Receives a byte stream over a valid/ready handshake (UART/host bridge side) and assembles 32-bit big-endian words.
- Writes the words into consecutive dmem addresses, starting at a programmable base.
- While loading: owns the dmem write port and holds the CPU; otherwise passes the CPU store port through unchanged.
- Replaces hard-coded memory initial images on FPGA builds.

Parameters:
- BYTES_PER_WORD, 4, bytes per dmem word; fixed to `DATA_W/8 (`DATA_W = 32 from def.h).
- ADDR_W, 16, dmem word-address width; matches the dmem address port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle load request; sampled only in IDLE or DONE.
- base_addr  in  ADDR_W  first dmem word address; latched on start.
- word_cnt  in  ADDR_W  number of words to load; latched on start.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- cpu_a  in  ADDR_W  CPU data address.
- cpu_wd  in  `DATA_W  CPU store data.
- cpu_we  in  1  CPU store enable.
- dmem_a  out  ADDR_W  to dmem a.
- dmem_wd  out  `DATA_W  to dmem wd.
- dmem_we  out  1  to dmem we.
- busy  out  1  load in progress.
- done  out  1  last load finished; level signal.
- cpu_hold  out  1  CPU stall/reset request; equals busy.

Behaviour:
- Async reset (rst_n low), effective immediately:
  - State = IDLE.
  - in_ready, busy, done, cpu_hold = 0.
  - Byte index, word shift register, address counter, remaining counter = 0.
  - Reset mid-load aborts with no further dmem writes. Words already written stay in dmem.
- States: IDLE, RECV, WRITE, DONE.
- Output mux (combinational):
  - IDLE/DONE: dmem_a/wd/we = cpu_a/wd/we.
  - RECV: dmem_we = 0; dmem_a/wd = loader regs (don't-care).
  - WRITE: dmem_a = addr, dmem_wd = assembled word, dmem_we = 1.
- IDLE/DONE on start:
  - word_cnt != 0: latch base_addr and word_cnt, clear byte index, done <= 0, go RECV.
  - word_cnt == 0: go DONE (done = 1 from next cycle), no writes.
- RECV:
  - in_ready = 1.
  - A byte is accepted when in_valid && in_ready. Big-endian assembly: 1st byte -> bits 31:24, 4th byte -> bits 7:0.
  - in_valid low: wait indefinitely, state unchanged.
  - After the 4th accepted byte: go WRITE.
- WRITE (exactly one cycle):
  - in_ready = 0; bytes presented this cycle are not accepted.
  - addr <= addr + 1, wrapping 16'hFFFF -> 16'h0000 with no error.
  - remaining <= remaining - 1.
  - If remaining was 1 go DONE, else go RECV with byte index 0.
- DONE:
  - busy = 0, cpu_hold = 0, done = 1.
  - done holds until the next start.
- busy/cpu_hold = 1 in RECV and WRITE.
- CPU inputs are ignored while busy; cpu_we during a load is dropped.
- start while busy is ignored.
- Latency:
  - dmem write occurs the cycle after the 4th byte handshake.
  - Back-to-back streaming: 5 cycles per word.
  - done rises the cycle after the last write.

Optional Feature:
- Macro DMEM_LDR_CSUM_EN.
- Defined:
  - Adds output csum [`DATA_W-1:0].
  - csum is cleared on accepted start and adds each written word in WRITE (mod 2^32).
  - csum is valid when done = 1 and holds until the next start. Reset value 0.
- Undefined: no csum port, no adder; all other behaviour identical.

Decomposition:
- Shared package / def.h additions:
  - State encoding constants LDR_IDLE/LDR_RECV/LDR_WRITE/LDR_DONE.
  - `DATA_W, `DMEM_DEPTH, byte width 8.
- One natural sub-module: byte_word_packer (byte-index counter + shift register; outputs word_valid pulse). Everything else stays in the top.

Test Plan:
- Reset then idle pass-through: cpu_a=5, cpu_wd=32'hDEADBEEF, cpu_we=1 -> dmem_a=5, dmem_wd=32'hDEADBEEF, dmem_we=1 combinationally; busy=0, done=0.
- Basic load: start, base=0, cnt=2; bytes 06 09 00 01 00 02 01 02 streamed back-to-back -> writes mem[0]=32'h06090001 and mem[1]=32'h00020102, one dmem_we cycle each, 5 cycles apart; done=1 the cycle after the 2nd write; csum=32'h060B0103 when DMEM_LDR_CSUM_EN is defined.
- Throttled stream: in_valid toggled 1/0 each cycle, base=3, cnt=1, bytes 01 03 02 03 -> single write mem[3]=32'h01030203; no write before the 4th handshake.
- Wrap and zero length: base=16'hFFFF, cnt=2 -> writes at FFFF then 0000. Separately, start with cnt=0 -> no dmem_we, done=1 next cycle.
- Conflicts: cpu_we=1 during RECV/WRITE -> dmem_we only in WRITE with loader address; start pulsed mid-load -> ignored, counters unchanged.
- Reset mid-load: rst_n low after 2 of 4 bytes -> immediate IDLE, no write, in_ready=0; a subsequent load of cnt=1 completes correctly from byte 0.
